// File: rtl/button_event_arbiter.sv
// Per-switch press/release/hold event detection with one pending slot per switch,
// round-robin merged onto a single valid/ready event channel.
module button_event_arbiter #(
    parameter int WIDTH          = 4,
    parameter int INDEX_WIDTH    = 2,
    parameter int HOLD_TICKS     = 1000,
    parameter int HOLD_CNT_WIDTH = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       in,
    output logic [WIDTH-1:0]       pressed,
    output logic                   evt_valid,
    input  logic                   evt_ready,
    output logic [INDEX_WIDTH-1:0] evt_index,
    output logic [1:0]             evt_kind,
    output logic                   overflow,
    input  logic                   overflow_clear
);

    typedef enum logic [1:0] {
        KIND_NONE    = 2'b00,
        KIND_PRESS   = 2'b01,
        KIND_RELEASE = 2'b10,
        KIND_HOLD    = 2'b11
    } kind_e;

    localparam bit                        HOLD_EN  = (HOLD_TICKS != 0);
    localparam logic [HOLD_CNT_WIDTH-1:0] HOLD_LIM = HOLD_CNT_WIDTH'(HOLD_TICKS);
    localparam logic [HOLD_CNT_WIDTH-1:0] HOLD_PRE = HOLD_CNT_WIDTH'(HOLD_TICKS - 1);
    localparam logic [INDEX_WIDTH:0]      WIDTH_V  = (INDEX_WIDTH + 1)'(WIDTH);

    logic [WIDTH-1:0]          pressed_q;
    logic [HOLD_CNT_WIDTH-1:0] holdCnt_q [WIDTH];
    logic [HOLD_CNT_WIDTH-1:0] holdCnt_d [WIDTH];
    logic [WIDTH-1:0]          fired_q;
    logic [WIDTH-1:0]          fired_d;
    logic [1:0]                slot_q [WIDTH];
    logic [1:0]                slot_d [WIDTH];
    logic [1:0]                newKind [WIDTH];

    logic [INDEX_WIDTH-1:0]    ptr_q;
    logic [INDEX_WIDTH-1:0]    ptr_d;
    logic                      valid_q;
    logic                      valid_d;
    logic [INDEX_WIDTH-1:0]    index_q;
    logic [INDEX_WIDTH-1:0]    index_d;
    logic [1:0]                kind_q;
    logic [1:0]                kind_d;
    logic                      overflow_q;
    logic                      overflow_d;

    logic [WIDTH-1:0]          occupied;
    logic [2*WIDTH-1:0]        occupiedDbl;
    logic [WIDTH-1:0]          rotated;
    logic                      found;
    logic [INDEX_WIDTH:0]      offset;
    logic [INDEX_WIDTH:0]      chosenSum;
    logic [INDEX_WIDTH:0]      nextSum;
    logic [INDEX_WIDTH-1:0]    chosen;
    logic [INDEX_WIDTH-1:0]    nextPtr;
    logic                      loadEn;
    logic                      takeSlot;
    logic                      ovfSet;

    // Edge detection and hold timing; a hold needs the switch still high this cycle
    // so it can never land together with that switch's release.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            newKind[i]   = KIND_NONE;
            holdCnt_d[i] = holdCnt_q[i];
            fired_d[i]   = fired_q[i];
            if (!pressed_q[i]) begin
                holdCnt_d[i] = '0;
                fired_d[i]   = 1'b0;
            end else if (holdCnt_q[i] != HOLD_LIM) begin
                holdCnt_d[i] = holdCnt_q[i] + 1'b1;
            end
            if (in[i] && !pressed_q[i]) begin
                newKind[i] = KIND_PRESS;
            end else if (!in[i] && pressed_q[i]) begin
                newKind[i] = KIND_RELEASE;
            end else if (HOLD_EN && in[i] && pressed_q[i] && !fired_q[i] &&
                         (holdCnt_q[i] == HOLD_PRE)) begin
                newKind[i] = KIND_HOLD;
                fired_d[i] = 1'b1;
            end
        end
    end

    // Rotate occupancy so bit 0 is the slot at ptr, then take the lowest set bit.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            occupied[i] = (slot_q[i] != KIND_NONE);
        end
        occupiedDbl = {occupied, occupied} >> ptr_q;
        rotated     = occupiedDbl[WIDTH-1:0];
        found       = 1'b0;
        offset      = '0;
        for (int k = WIDTH - 1; k >= 0; k--) begin
            if (rotated[k]) begin
                found  = 1'b1;
                offset = (INDEX_WIDTH + 1)'(k);
            end
        end
        chosenSum = {1'b0, ptr_q} + offset;
        if (chosenSum >= WIDTH_V) begin
            chosenSum = chosenSum - WIDTH_V;
        end
        chosen  = chosenSum[INDEX_WIDTH-1:0];
        nextSum = {1'b0, chosen} + 1'b1;
        if (nextSum >= WIDTH_V) begin
            nextSum = '0;
        end
        nextPtr = nextSum[INDEX_WIDTH-1:0];
    end

    always_comb begin
        loadEn   = !valid_q || evt_ready;
        takeSlot = loadEn && found;
        valid_d  = valid_q;
        index_d  = index_q;
        kind_d   = kind_q;
        ptr_d    = ptr_q;
        if (loadEn) begin
            valid_d = found;
            if (found) begin
                index_d = chosen;
                ptr_d   = nextPtr;
                for (int i = 0; i < WIDTH; i++) begin
                    if (INDEX_WIDTH'(i) == chosen) begin
                        kind_d = slot_q[i];
                    end
                end
            end
        end
    end

    // A slot being handed to the output this cycle can accept a new event without loss.
    always_comb begin
        ovfSet = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            slot_d[i] = slot_q[i];
            if (takeSlot && (INDEX_WIDTH'(i) == chosen)) begin
                slot_d[i] = KIND_NONE;
                if (newKind[i] != KIND_NONE) begin
                    slot_d[i] = newKind[i];
                end
            end else if (newKind[i] != KIND_NONE) begin
                if (slot_q[i] != KIND_NONE) begin
                    ovfSet = 1'b1;
                end
                slot_d[i] = newKind[i];
            end
        end
        overflow_d = overflow_q;
        if (overflow_clear) begin
            overflow_d = 1'b0;
        end
        if (ovfSet) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pressed_q  <= '0;
            fired_q    <= '0;
            ptr_q      <= '0;
            valid_q    <= 1'b0;
            index_q    <= '0;
            kind_q     <= KIND_NONE;
            overflow_q <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                holdCnt_q[i] <= '0;
                slot_q[i]    <= KIND_NONE;
            end
        end else begin
            pressed_q  <= in;
            fired_q    <= fired_d;
            ptr_q      <= ptr_d;
            valid_q    <= valid_d;
            index_q    <= index_d;
            kind_q     <= kind_d;
            overflow_q <= overflow_d;
            for (int i = 0; i < WIDTH; i++) begin
                holdCnt_q[i] <= holdCnt_d[i];
                slot_q[i]    <= slot_d[i];
            end
        end
    end

    assign pressed   = pressed_q;
    assign evt_valid = valid_q;
    assign evt_index = index_q;
    assign evt_kind  = kind_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed bench for button_event_arbiter: expected events go into a queue and a
// forked monitor compares every accepted event against it.
module tb_button_event_arbiter;

    localparam int WIDTH = 4;
    localparam int IW    = 2;
    localparam int HT    = 8;
    localparam int HCW   = 10;

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] in;
    logic [WIDTH-1:0] pressed;
    logic             evt_valid;
    logic             evt_ready;
    logic [IW-1:0]    evt_index;
    logic [1:0]       evt_kind;
    logic             overflow;
    logic             overflow_clear;

    int               checks = 0;
    int               errors = 0;
    logic [IW+1:0]    expQ[$];

    always #5 clk = ~clk;

    button_event_arbiter #(
        .WIDTH(WIDTH), .INDEX_WIDTH(IW), .HOLD_TICKS(HT), .HOLD_CNT_WIDTH(HCW)
    ) dut (
        .clk(clk), .reset(reset), .in(in), .pressed(pressed),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_index(evt_index),
        .evt_kind(evt_kind), .overflow(overflow), .overflow_clear(overflow_clear)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [WIDTH-1:0] v);
        in = v;
    endtask

    task automatic pushExp(input int idx, input logic [1:0] kind);
        expQ.push_back({IW'(idx), kind});
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkEvent(input string name, input int idx, input logic [1:0] kind);
        checkOutput({name, "_valid"}, 32'(evt_valid), 32'd1);
        checkOutput({name, "_payload"}, 32'({evt_index, evt_kind}), 32'({IW'(idx), kind}));
    endtask

    task automatic monitorLoop();
        logic [IW+1:0] exp;
        forever begin
            @(negedge clk);
            if (!reset && evt_valid && evt_ready) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_event actual=%0h expected=none",
                             {evt_index, evt_kind});
                end else begin
                    exp = expQ.pop_front();
                    checkOutput("accepted_event", 32'({evt_index, evt_kind}), 32'(exp));
                end
            end
        end
    endtask

    initial begin
        reset          = 1'b1;
        in             = '0;
        evt_ready      = 1'b0;
        overflow_clear = 1'b0;
        fork
            monitorLoop();
        join_none

        tick(5);
        checkOutput("reset_pressed", 32'(pressed), 32'd0);
        checkOutput("reset_valid", 32'(evt_valid), 32'd0);
        checkOutput("reset_payload", 32'({evt_index, evt_kind}), 32'd0);
        checkOutput("reset_overflow", 32'(overflow), 32'd0);
        reset     = 1'b0;
        evt_ready = 1'b1;
        tick(2);

        // Single press: valid two edges after the input change, for one cycle.
        applyStimulus(4'b0001);
        pushExp(0, 2'b01);
        tick(1);
        checkOutput("press_latency", 32'(evt_valid), 32'd0);
        tick(1);
        checkEvent("press0", 0, 2'b01);
        tick(1);
        checkOutput("press0_oneshot", 32'(evt_valid), 32'd0);
        checkOutput("press0_overflow", 32'(overflow), 32'd0);
        applyStimulus(4'b0000);
        pushExp(0, 2'b10);
        tick(3);

        // Stalled consumer, then back-to-back delivery in index order.
        evt_ready = 1'b0;
        applyStimulus(4'b0110);
        pushExp(1, 2'b01);
        pushExp(2, 2'b01);
        tick(4);
        checkEvent("stall_head", 1, 2'b01);
        evt_ready = 1'b1;
        tick(1);
        checkEvent("b2b_second", 2, 2'b01);
        tick(1);
        checkOutput("b2b_drained", 32'(evt_valid), 32'd0);
        applyStimulus(4'b0010);
        tick(1);
        applyStimulus(4'b0000);
        pushExp(2, 2'b10);
        pushExp(1, 2'b10);
        tick(4);
        checkOutput("release12_drained", 32'(evt_valid), 32'd0);

        // Pointer sits at 2, so switch 3 wins over switch 0.
        applyStimulus(4'b1001);
        pushExp(3, 2'b01);
        pushExp(0, 2'b01);
        tick(1);
        checkOutput("rr_latency", 32'(evt_valid), 32'd0);
        tick(1);
        checkEvent("rr_first", 3, 2'b01);
        tick(1);
        checkEvent("rr_second", 0, 2'b01);
        tick(1);
        checkOutput("rr_drained", 32'(evt_valid), 32'd0);
        applyStimulus(4'b0000);
        pushExp(3, 2'b10);
        pushExp(0, 2'b10);
        tick(4);
        checkOutput("rr_release_drained", 32'(evt_valid), 32'd0);

        // Long hold: exactly one hold event, slot written 8 edges after the press.
        applyStimulus(4'b0001);
        pushExp(0, 2'b01);
        pushExp(0, 2'b11);
        pushExp(0, 2'b10);
        tick(1);
        checkOutput("hold_press_latency", 32'(evt_valid), 32'd0);
        tick(1);
        checkEvent("hold_press", 0, 2'b01);
        tick(7);
        checkOutput("hold_not_early", 32'(evt_valid), 32'd0);
        tick(1);
        checkEvent("hold_event", 0, 2'b11);
        tick(1);
        checkOutput("hold_oneshot", 32'(evt_valid), 32'd0);
        tick(10);
        applyStimulus(4'b0000);
        tick(4);
        checkOutput("hold_release_drained", 32'(evt_valid), 32'd0);

        // Overflow: switch 3 rises and falls while the output is stalled on switch 1.
        evt_ready = 1'b0;
        applyStimulus(4'b0010);
        pushExp(1, 2'b01);
        tick(2);
        checkEvent("ovf_busy", 1, 2'b01);
        applyStimulus(4'b1010);
        tick(2);
        checkOutput("ovf_not_yet", 32'(overflow), 32'd0);
        applyStimulus(4'b0000);
        pushExp(3, 2'b10);
        pushExp(1, 2'b10);
        tick(1);
        checkOutput("ovf_set", 32'(overflow), 32'd1);
        checkEvent("ovf_stall_stable", 1, 2'b01);
        evt_ready = 1'b1;
        tick(1);
        checkEvent("ovf_latest_kind", 3, 2'b10);
        tick(1);
        checkEvent("ovf_release1", 1, 2'b10);
        tick(1);
        checkOutput("ovf_drained", 32'(evt_valid), 32'd0);
        checkOutput("ovf_sticky", 32'(overflow), 32'd1);
        overflow_clear = 1'b1;
        tick(1);
        overflow_clear = 1'b0;
        checkOutput("ovf_cleared", 32'(overflow), 32'd0);

        // Reset mid-operation discards everything in flight.
        evt_ready = 1'b0;
        applyStimulus(4'b0111);
        tick(3);
        checkEvent("pre_reset_busy", 2, 2'b01);
        reset = 1'b1;
        applyStimulus(4'b0000);
        expQ.delete();
        tick(1);
        checkOutput("midreset_valid", 32'(evt_valid), 32'd0);
        checkOutput("midreset_overflow", 32'(overflow), 32'd0);
        checkOutput("midreset_pressed", 32'(pressed), 32'd0);
        reset     = 1'b0;
        evt_ready = 1'b1;
        tick(10);
        checkOutput("post_reset_quiet", 32'(evt_valid), 32'd0);

        checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
